// File: rtl/queue_pkg.sv
// Shared definitions for the two-wide-pop queue: pop request encodings and
// a helper that maps a pop request to the number of entries it consumes.
package queue_pkg;

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2,
    POP_RSVD = 2'd3
  } pop_e;

  // Entries a pop request wants to remove; the reserved code asks for none.
  function automatic logic [1:0] pop_need(input pop_e kind);
    case (kind)
      POP_ONE: pop_need = 2'd1;
      POP_TWO: pop_need = 2'd2;
      default: pop_need = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/queue_n.sv
// Circular-buffer queue with single-word push and one- or two-word pop.
// The oldest two entries are always presented on o_rd_data0/o_rd_data1.
module queue_n
  import queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AFULL = DEPTH - 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic [1:0]                 i_rd,
  output logic [WIDTH-1:0]           o_rd_data0,
  output logic [WIDTH-1:0]           o_rd_data1,
  output logic [1:0]                 o_vld,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_afull,
  output logic                       o_wr_err,
  output logic                       o_rd_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_err_q, wr_err_d;
  logic             rd_err_q, rd_err_d;

  pop_e             pop_kind;
  logic [1:0]       want_n;
  logic [1:0]       pop_n;
  logic             wr_ok;
  logic [PTR_W-1:0] rd_ptr_p1;

  // Handshake: i_wr and i_rd are requests sampled on every rising edge.
  // Acceptance is decided solely from the pre-edge registered count: a write
  // needs a free slot before the edge (no write-through on full, even with a
  // same-edge pop), a pop of n needs n stored entries. A rejected request has
  // no effect on contents and is flagged by a one-cycle o_wr_err/o_rd_err
  // pulse in the following cycle.
  always_comb begin
    pop_kind = pop_e'(i_rd);
    want_n   = pop_need(pop_kind);
    wr_ok    = i_wr && (count_q != DEPTH_C);
    wr_err_d = i_wr && (count_q == DEPTH_C);
    pop_n    = 2'd0;
    rd_err_d = 1'b0;
    if (pop_kind == POP_RSVD) begin
      rd_err_d = 1'b1;
    end else if (want_n != 2'd0) begin
      if (count_q >= CNT_W'(want_n)) begin
        pop_n = want_n;
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  // Count never wraps: a write needs a free slot, a pop needs enough entries.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
    count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(pop_n);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_ok && !i_rst) begin
      mem_d[wr_ptr_q] = i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage is deliberately not cleared by reset; count gates visibility.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

  always_comb begin
    o_vld[0]   = (count_q >= CNT_W'(1));
    o_vld[1]   = (count_q >= CNT_W'(2));
    o_count    = count_q;
    o_full     = (count_q == DEPTH_C);
    o_empty    = (count_q == '0);
    o_afull    = (count_q >= AFULL_C);
    o_wr_err   = wr_err_q;
    o_rd_err   = rd_err_q;
    o_rd_data0 = o_vld[0] ? mem_q[rd_ptr_q]  : '0;
    o_rd_data1 = o_vld[1] ? mem_q[rd_ptr_p1] : '0;
  end

endmodule

// File: tb/tb_queue_n.sv
// Directed bench for queue_n (DEPTH=8, AFULL=6) followed by a seeded random
// traffic phase checked against a queue-based reference model.
module tb_queue_n;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             i_clk;
  logic             i_rst;
  logic             i_wr;
  logic [WIDTH-1:0] i_wr_data;
  logic [1:0]       i_rd;
  logic [WIDTH-1:0] o_rd_data0;
  logic [WIDTH-1:0] o_rd_data1;
  logic [1:0]       o_vld;
  logic [3:0]       o_count;
  logic             o_full;
  logic             o_empty;
  logic             o_afull;
  logic             o_wr_err;
  logic             o_rd_err;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  queue_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr       (i_wr),
    .i_wr_data  (i_wr_data),
    .i_rd       (i_rd),
    .o_rd_data0 (o_rd_data0),
    .o_rd_data1 (o_rd_data1),
    .o_vld      (o_vld),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_afull    (o_afull),
    .o_wr_err   (o_wr_err),
    .o_rd_err   (o_rd_err)
  );

  // Clock and reset defaults
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, return 1ns after the edge.
  task automatic cyc(input logic rst, input logic wr, input logic [WIDTH-1:0] d,
                     input logic [1:0] rd);
    i_rst = rst;
    i_wr = wr;
    i_wr_data = d;
    i_rd = rd;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_wr = 1'b0;
    i_rd = 2'd0;
  endtask

  task automatic chk_status(input string tag, input logic [3:0] cnt, input logic [1:0] vld,
                            input logic full, input logic empty, input logic afull);
    chk({tag, "_count"}, 64'(o_count), 64'(cnt));
    chk({tag, "_vld"},   64'(o_vld),   64'(vld));
    chk({tag, "_full"},  64'(o_full),  64'(full));
    chk({tag, "_empty"}, 64'(o_empty), 64'(empty));
    chk({tag, "_afull"}, 64'(o_afull), 64'(afull));
  endtask

  // Scoreboard step: one random cycle, model update, and full output compare.
  task automatic rand_step(input logic rst);
    logic             wr;
    logic [1:0]       rd;
    logic [WIDTH-1:0] d;
    logic             exp_wr_err;
    logic             exp_rd_err;
    int               n;
    int               sz;
    wr = ($urandom_range(0, 99) < 55);
    rd = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 49) == 0) rd = 2'd3;
    d  = $urandom;
    sz = exp_q.size();
    n  = (rd == 2'd1) ? 1 : (rd == 2'd2) ? 2 : 0;
    exp_wr_err = wr && (sz == DEPTH);
    exp_rd_err = (rd == 2'd3) || (n > sz);
    cyc(rst, wr, d, rd);
    if (rst) begin
      exp_q.delete();
      exp_wr_err = 1'b0;
      exp_rd_err = 1'b0;
    end else begin
      if (n <= sz) begin
        for (int k = 0; k < n; k++) void'(exp_q.pop_front());
      end
      if (wr && sz < DEPTH) exp_q.push_back(d);
    end
    sz = exp_q.size();
    chk("rnd_count",  64'(o_count),  64'(sz));
    chk("rnd_vld",    64'(o_vld),    64'({sz >= 2, sz >= 1}));
    chk("rnd_full",   64'(o_full),   64'(sz == DEPTH));
    chk("rnd_empty",  64'(o_empty),  64'(sz == 0));
    chk("rnd_afull",  64'(o_afull),  64'(sz >= 6));
    chk("rnd_wr_err", 64'(o_wr_err), 64'(exp_wr_err));
    chk("rnd_rd_err", 64'(o_rd_err), 64'(exp_rd_err));
    chk("rnd_data0",  64'(o_rd_data0), 64'((sz >= 1) ? exp_q[0] : '0));
    chk("rnd_data1",  64'(o_rd_data1), 64'((sz >= 2) ? exp_q[1] : '0));
  endtask

  initial begin
    logic did_reset;
    i_rst = 1'b1;
    i_wr = 1'b0;
    i_wr_data = '0;
    i_rd = 2'd0;
    @(negedge i_clk);

    // Reset state
    cyc(1'b1, 1'b0, '0, 2'd0);
    cyc(1'b1, 1'b0, '0, 2'd0);
    chk_status("rst", 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("rst_d0", 64'(o_rd_data0), 64'h0);
    chk("rst_d1", 64'(o_rd_data1), 64'h0);
    chk("rst_wr_err", 64'(o_wr_err), 64'h0);
    chk("rst_rd_err", 64'(o_rd_err), 64'h0);

    // Two writes; first is visible right after its edge
    cyc(1'b0, 1'b1, 32'h11, 2'd0);
    chk("lat_d0", 64'(o_rd_data0), 64'h11);
    chk_status("lat", 4'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h22, 2'd0);
    chk_status("two", 4'd2, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("two_d0", 64'(o_rd_data0), 64'h11);
    chk("two_d1", 64'(o_rd_data1), 64'h22);
    cyc(1'b0, 1'b0, '0, 2'd2);
    chk_status("pop2_empty", 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);

    // Fill with 1..8, check almost-full threshold and full
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 32'(i), 2'd0);
      chk("fill_count", 64'(o_count), 64'(i));
      chk("fill_afull", 64'(o_afull), 64'(i >= 6));
    end
    chk_status("full", 4'd8, 2'b11, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 32'h99, 2'd0);
    chk("ovf_wr_err", 64'(o_wr_err), 64'h1);
    chk("ovf_count", 64'(o_count), 64'd8);
    cyc(1'b0, 1'b0, '0, 2'd0);
    chk("ovf_wr_err_clr", 64'(o_wr_err), 64'h0);

    // Full plus pop: pop accepted, write rejected (no write-through)
    cyc(1'b0, 1'b1, 32'h99, 2'd1);
    chk("fullpop_wr_err", 64'(o_wr_err), 64'h1);
    chk("fullpop_count", 64'(o_count), 64'd7);
    chk("fullpop_d0", 64'(o_rd_data0), 64'h2);
    cyc(1'b0, 1'b0, '0, 2'd2);
    chk("pop2_d0", 64'(o_rd_data0), 64'h4);
    chk("pop2_d1", 64'(o_rd_data1), 64'h5);
    chk("pop2_count", 64'(o_count), 64'd5);

    // Reserved pop at count 5
    cyc(1'b0, 1'b0, '0, 2'd3);
    chk("rsvd_rd_err", 64'(o_rd_err), 64'h1);
    chk("rsvd_count", 64'(o_count), 64'd5);
    chk("rsvd_d0", 64'(o_rd_data0), 64'h4);

    // Drain to one entry, checking order; 0x99 must never appear
    for (int i = 5; i <= 8; i++) begin
      cyc(1'b0, 1'b0, '0, 2'd1);
      chk("drain_d0", 64'(o_rd_data0), 64'(i));
    end
    chk("drain_rd_err", 64'(o_rd_err), 64'h0);

    // Pop-two with one entry is rejected
    cyc(1'b0, 1'b0, '0, 2'd2);
    chk("under_rd_err", 64'(o_rd_err), 64'h1);
    chk_status("under", 4'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("under_d0", 64'(o_rd_data0), 64'h8);
    cyc(1'b0, 1'b0, '0, 2'd0);
    chk("under_rd_err_clr", 64'(o_rd_err), 64'h0);
    cyc(1'b0, 1'b0, '0, 2'd1);
    chk("empty_again", 64'(o_empty), 64'h1);

    // Simultaneous write and pop-two
    cyc(1'b0, 1'b1, 32'hA, 2'd0);
    cyc(1'b0, 1'b1, 32'hB, 2'd0);
    cyc(1'b0, 1'b1, 32'hC, 2'd2);
    chk_status("wrpop", 4'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    chk("wrpop_d0", 64'(o_rd_data0), 64'hC);
    chk("wrpop_d1", 64'(o_rd_data1), 64'h0);
    cyc(1'b0, 1'b0, '0, 2'd1);

    // Pointers now rd=wr=5: two fillers move both to 7, then wrap
    cyc(1'b0, 1'b1, 32'h55, 2'd0);
    cyc(1'b0, 1'b1, 32'h66, 2'd0);
    cyc(1'b0, 1'b0, '0, 2'd2);
    cyc(1'b0, 1'b1, 32'h70, 2'd0);
    cyc(1'b0, 1'b1, 32'h80, 2'd0);
    chk("wrap_d0", 64'(o_rd_data0), 64'h70);
    chk("wrap_d1", 64'(o_rd_data1), 64'h80);
    cyc(1'b0, 1'b0, '0, 2'd2);
    chk_status("wrap_pop2", 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("wrap_pop2_d0", 64'(o_rd_data0), 64'h0);
    chk("wrap_pop2_d1", 64'(o_rd_data1), 64'h0);

    // Reset overrides a same-cycle write
    cyc(1'b0, 1'b1, 32'h1, 2'd0);
    cyc(1'b0, 1'b1, 32'h2, 2'd0);
    cyc(1'b1, 1'b1, 32'h3, 2'd1);
    chk_status("midrst", 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("midrst_d0", 64'(o_rd_data0), 64'h0);
    cyc(1'b0, 1'b1, 32'h44, 2'd0);
    chk("post_rst_d0", 64'(o_rd_data0), 64'h44);
    cyc(1'b0, 1'b0, '0, 2'd1);

    // Random traffic with a reset injected once the model reaches 6 entries
    exp_q.delete();
    did_reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!did_reset && c > 300 && exp_q.size() == 6) begin
        did_reset = 1'b1;
        rand_step(1'b1);
        chk("rnd_reset_count", 64'(o_count), 64'h0);
      end else begin
        rand_step(1'b0);
      end
    end
    chk("rnd_reset_seen", 64'(did_reset), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
